// File: rtl/seq_scan_ctrl_if.sv
// seq_scan_ctrl_if: handshake, result and detector-side signals of seq_scan_ctrl
interface seq_scan_ctrl_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5,
    parameter int POS_W = 4
);
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] data_in;
    logic             det_y;
    logic             det_x;
    logic             det_reset;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] match_count;
    logic [POS_W-1:0] first_pos;
    logic             any_match;
    modport master (
        output start, abort, data_in, det_y,
        input  det_x, det_reset, busy, done, match_count, first_pos, any_match
    );
    modport slave (
        input  start, abort, data_in, det_y,
        output det_x, det_reset, busy, done, match_count, first_pos, any_match
    );
endinterface

// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: shifts a word MSB-first through an external 1101 Moore detector and reports matches
module seq_scan_ctrl #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5,
    parameter int POS_W = 4
) (
    input logic clk,
    input logic reset,
    seq_scan_ctrl_if.slave bus
);
    localparam int IW = POS_W + 1;
    typedef enum logic [1:0] {IDLE, SHIFT, FLUSH, DONE} state_t;
    state_t           state, state_n;
    logic [WIDTH-1:0] sr;
    logic [IW-1:0]    idx;
    logic [CNT_W-1:0] acc_cnt, acc_cnt_n, res_cnt;
    logic [POS_W-1:0] acc_pos, acc_pos_n, res_pos;
    logic             acc_any, acc_any_n, res_any, hit, run;
    always_ff @(posedge clk) state <= reset ? IDLE : state_n;
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    state_n = bus.start ? SHIFT : IDLE;
            SHIFT:   state_n = bus.abort ? IDLE : idx == IW'(WIDTH - 1) ? FLUSH : SHIFT;
            FLUSH:   state_n = bus.abort ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
        hit       = bus.det_y && ((state == SHIFT && idx != '0) || state == FLUSH);
        acc_cnt_n = hit && acc_cnt != '1 ? acc_cnt + 1'b1 : acc_cnt;
        acc_pos_n = hit && !acc_any ? POS_W'(idx - 1'b1) : acc_pos;
        acc_any_n = acc_any | hit;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            sr      <= '0;
            idx     <= '0;
            acc_cnt <= '0;
            acc_pos <= '0;
            acc_any <= 1'b0;
            res_cnt <= '0;
            res_pos <= '0;
            res_any <= 1'b0;
        end else begin
            if (state == IDLE && bus.start) begin
                sr      <= bus.data_in;
                idx     <= '0;
                acc_cnt <= '0;
                acc_pos <= '0;
                acc_any <= 1'b0;
            end else begin
                acc_cnt <= acc_cnt_n;
                acc_pos <= acc_pos_n;
                acc_any <= acc_any_n;
            end
            if (state == SHIFT) begin
                sr  <= sr << 1;
                idx <= idx + 1'b1;
            end
            if (state == FLUSH && !bus.abort) begin
                res_cnt <= acc_cnt_n;
                res_pos <= acc_pos_n;
                res_any <= acc_any_n;
            end
        end
    end
    assign run             = state == SHIFT || state == FLUSH;
    assign bus.det_x       = state == SHIFT && sr[WIDTH-1];
    assign bus.det_reset   = run;
    assign bus.busy        = run;
    assign bus.done        = state == DONE;
    assign bus.match_count = res_cnt;
    assign bus.first_pos   = res_pos;
    assign bus.any_match   = res_any;
endmodule

// File: tb/tb_seq_scan_ctrl.sv
// tb_seq_scan_ctrl: drives two controllers (CNT_W 5 and 2) against stub 1101 detectors
module tb_seq_scan_ctrl;
    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0;
    logic [15:0] data_in = '0;
    logic [3:0]  h0 = '0, h1 = '0;
    int          n0 = 0, n1 = 0;
    int          errors = 0, checks = 0;
    seq_scan_ctrl_if #(.WIDTH(16), .CNT_W(5), .POS_W(4)) if0 ();
    seq_scan_ctrl_if #(.WIDTH(16), .CNT_W(2), .POS_W(4)) if1 ();
    seq_scan_ctrl #(.WIDTH(16), .CNT_W(5), .POS_W(4)) u0 (.clk(clk), .reset(reset), .bus(if0));
    seq_scan_ctrl #(.WIDTH(16), .CNT_W(2), .POS_W(4)) u1 (.clk(clk), .reset(reset), .bus(if1));
    always #5 clk = ~clk;
    assign if0.start = start;
    assign if1.start = start;
    assign if0.abort = abort;
    assign if1.abort = abort;
    assign if0.data_in = data_in;
    assign if1.data_in = data_in;
    always @(posedge clk) begin
        if (!if0.det_reset) begin h0 <= '0; n0 <= 0; end
        else begin h0 <= {h0[2:0], if0.det_x}; n0 <= n0 < 4 ? n0 + 1 : 4; end
        if (!if1.det_reset) begin h1 <= '0; n1 <= 0; end
        else begin h1 <= {h1[2:0], if1.det_x}; n1 <= n1 < 4 ? n1 + 1 : 4; end
    end
    assign if0.det_y = n0 == 4 && h0 == 4'b1101;
    assign if1.det_y = n1 == 4 && h1 == 4'b1101;

    typedef struct {
        logic [15:0] d;
        int cnt;
        int pos;
        int any;
        int sat;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void model(input logic [15:0] w, input int cmax,
                                  output int cnt, output int pos, output int any);
        logic [3:0] win;
        cnt = 0; pos = 0; any = 0;
        for (int p = 3; p < 16; p++) begin
            win = w[18-p -: 4];
            if (win == 4'b1101) begin
                if (any == 0) pos = p;
                any = 1;
                if (cnt < cmax) cnt++;
            end
        end
    endfunction

    task automatic watch(input int n, output int dones);
        dones = 0;
        repeat (n) begin
            @(negedge clk);
            if (if0.done) dones++;
        end
    endtask

    task automatic scan(input logic [15:0] d, input int e_cnt, input int e_pos,
                        input int e_any, input int e_sat, input string tag);
        int cyc, busy_n;
        logic [15:0] stream;
        bit got;
        @(negedge clk); start = 1'b1; data_in = d;
        @(negedge clk); start = 1'b0;
        cyc = 1; busy_n = 0; stream = '0; got = 0;
        while (!got && cyc <= 40) begin
            if (if0.busy) busy_n++;
            if (cyc <= 16) stream = {stream[14:0], if0.det_x};
            if (if0.done) begin
                got = 1;
                check({tag, " done_cycle"}, cyc, 18);
                check({tag, " busy_cycles"}, busy_n, 17);
                check({tag, " det_x_stream"}, int'(stream), int'(d));
                check({tag, " match_count"}, int'(if0.match_count), e_cnt);
                check({tag, " first_pos"}, int'(if0.first_pos), e_pos);
                check({tag, " any_match"}, int'(if0.any_match), e_any);
                check({tag, " sat_count"}, int'(if1.match_count), e_sat);
                check({tag, " sat_any"}, int'(if1.any_match), e_any);
                check({tag, " sat_done"}, int'(if1.done), 1);
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!got) check({tag, " done_timeout"}, 0, 1);
        @(negedge clk);
        check({tag, " done_pulse"}, int'(if0.done), 0);
        check({tag, " hold_count"}, int'(if0.match_count), e_cnt);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int dones, m_cnt, m_pos, m_any, m_sat, m_pos2, m_any2;
        logic [15:0] w;
        logic [3:0] nib;
        vecs[0] = '{16'hD000, 1, 3, 1, 1};
        vecs[1] = '{16'hDDDD, 4, 3, 1, 3};
        vecs[2] = '{16'hDB00, 2, 3, 1, 2};
        vecs[3] = '{16'h0000, 0, 0, 0, 0};
        vecs[4] = '{16'hFFFF, 0, 0, 0, 0};
        vecs[5] = '{16'h000D, 1, 15, 1, 1};

        repeat (3) @(negedge clk);
        check("reset busy", int'(if0.busy), 0);
        check("reset done", int'(if0.done), 0);
        check("reset det_x", int'(if0.det_x), 0);
        check("reset det_reset", int'(if0.det_reset), 0);
        check("reset match_count", int'(if0.match_count), 0);
        check("reset first_pos", int'(if0.first_pos), 0);
        check("reset any_match", int'(if0.any_match), 0);
        reset = 1'b0;

        for (int i = 0; i < 6; i++)
            scan(vecs[i].d, vecs[i].cnt, vecs[i].pos, vecs[i].any, vecs[i].sat, $sformatf("vec%0d", i));

        @(negedge clk); start = 1'b1; data_in = 16'hDDDD;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midreset busy", int'(if0.busy), 0);
        check("midreset det_reset", int'(if0.det_reset), 0);
        check("midreset done", int'(if0.done), 0);
        check("midreset match_count", int'(if0.match_count), 0);
        check("midreset first_pos", int'(if0.first_pos), 0);
        check("midreset any_match", int'(if0.any_match), 0);
        reset = 1'b0;
        watch(25, dones);
        check("midreset no_done", dones, 0);
        scan(16'hD000, 1, 3, 1, 1, "after_reset");

        @(negedge clk); start = 1'b1; data_in = 16'hDDDD;
        @(negedge clk); start = 1'b0;
        repeat (7) @(negedge clk);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        check("abort_shift busy", int'(if0.busy), 0);
        check("abort_shift det_reset", int'(if0.det_reset), 0);
        watch(25, dones);
        check("abort_shift no_done", dones, 0);
        check("abort_shift match_count", int'(if0.match_count), 1);
        check("abort_shift first_pos", int'(if0.first_pos), 3);

        @(negedge clk); start = 1'b1; data_in = 16'hDDDD;
        @(negedge clk); start = 1'b0;
        repeat (16) @(negedge clk);
        check("flush busy", int'(if0.busy), 1);
        check("flush det_x", int'(if0.det_x), 0);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        check("abort_flush busy", int'(if0.busy), 0);
        watch(25, dones);
        check("abort_flush no_done", dones, 0);
        check("abort_flush match_count", int'(if0.match_count), 1);

        @(negedge clk); start = 1'b1; abort = 1'b1; data_in = 16'hDDDD;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        check("start_beats_abort busy", int'(if0.busy), 1);
        repeat (5) @(negedge clk);
        start = 1'b1; data_in = 16'h0000;
        @(negedge clk); start = 1'b0;
        watch(30, dones);
        check("start_while_busy dones", dones, 1);
        check("start_while_busy match_count", int'(if0.match_count), 4);
        check("start_while_busy sat_count", int'(if1.match_count), 3);

        for (int r = 0; r < 24; r++) begin
            w = '0;
            for (int k = 0; k < 4; k++) begin
                case ($urandom_range(0, 3))
                    0: nib = 4'hD;
                    1: nib = 4'hB;
                    2: nib = 4'h6;
                    default: nib = 4'($urandom);
                endcase
                w = {w[11:0], nib};
            end
            model(w, 31, m_cnt, m_pos, m_any);
            model(w, 3, m_sat, m_pos2, m_any2);
            scan(w, m_cnt, m_pos, m_any, m_sat, $sformatf("rand%0d_%04h", r, w));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
